// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg
// Shared widths, enable levels, FSM encoding and the word-align helper
// used by the instruction cache controller and its storage array.
package icache_ctrl_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Instructions are word aligned; pc[1:0] never reaches the array or memory.
    localparam logic [ADDRESS_WIDTH-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    function automatic logic [ADDRESS_WIDTH-1:0] word_align(
        input logic [ADDRESS_WIDTH-1:0] addr
    );
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/icache_ctrl_array.sv
// icache_array
// Direct-mapped line storage: data and tag RAM with synchronous write and
// combinational read, plus a separate valid vector that can be bulk-cleared.
// A fill in the same cycle as a bulk clear leaves the filled line valid.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (valid bits only)
//   i_we           : write data/tag at i_widx and set its valid bit
//   i_widx/i_wtag/i_wdata : write index, tag and instruction word
//   i_clr_all      : clear every valid bit
//   i_ridx         : read index
//   o_rdata/o_rtag/o_rvalid : combinational read of line i_ridx
module icache_array
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_we,
    input  logic [INDEX_BITS-1:0]        i_widx,
    input  logic [TAG_BITS-1:0]          i_wtag,
    input  logic [INSTRUCTION_WIDTH-1:0] i_wdata,
    input  logic                         i_clr_all,
    input  logic [INDEX_BITS-1:0]        i_ridx,
    output logic [INSTRUCTION_WIDTH-1:0] o_rdata,
    output logic [TAG_BITS-1:0]          o_rtag,
    output logic                         o_rvalid
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [INSTRUCTION_WIDTH-1:0] r_data [DEPTH];
    logic [TAG_BITS-1:0]          r_tag  [DEPTH];
    logic [DEPTH-1:0]             r_valid;

    // Data and tag need no reset: the valid vector gates every use.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_data[i_widx] <= i_wdata;
            r_tag[i_widx]  <= i_wtag;
        end
    end

    // Clear first, then fill, so a coincident fill survives the invalidate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else begin
            if (i_clr_all) begin
                r_valid <= '0;
            end
            if (i_we) begin
                r_valid[i_widx] <= ENABLE;
            end
        end
    end

    assign o_rdata  = r_data[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rvalid = r_valid[i_ridx];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl
// Direct-mapped, one-word-per-line instruction cache controller. A request
// is latched in IDLE, looked up the next cycle, and on a miss a single word
// is refilled from the memory controller fetch port.
//
// Ports:
//   clk_in, rst_n_in          : clock, async active-low reset
//   rdy_in                    : global enable, 0 freezes all state
//   ifetch_req_in/pc_in       : fetch request and address
//   ifetch_rdy_out            : ready for a new request (IDLE)
//   ifetch_valid_out/inst_out : one-cycle result pulse and instruction
//   flush_in                  : abort any outstanding fetch
//   inval_in                  : invalidate all lines
//   mem_en_out/mem_pc_out     : refill request level and word address
//   mem_done_in/mem_inst_in   : refill completion pulse and word
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for a request, ifetch_rdy_out=1
// ST_LOOKUP | latched pc checked against the array
// ST_REFILL | miss outstanding, mem_en_out held until mem_done_in
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         ifetch_req_in,
    input  logic [ADDRESS_WIDTH-1:0]     ifetch_pc_in,
    output logic                         ifetch_rdy_out,
    output logic                         ifetch_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] ifetch_inst_out,
    input  logic                         flush_in,
    input  logic                         inval_in,
    output logic                         mem_en_out,
    output logic [ADDRESS_WIDTH-1:0]     mem_pc_out,
    input  logic                         mem_done_in,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_inst_in
);

    localparam int TAG_BITS = ADDRESS_WIDTH - 2 - INDEX_BITS;

    state_t                       r_state;
    logic [ADDRESS_WIDTH-1:0]     r_pc;
    logic                         r_valid_out;
    logic [INSTRUCTION_WIDTH-1:0] r_inst;
    logic [ADDRESS_WIDTH-1:0]     r_mem_pc;

    logic [INDEX_BITS-1:0]        w_idx;
    logic [TAG_BITS-1:0]          w_tag;
    logic [INSTRUCTION_WIDTH-1:0] w_rdata;
    logic [TAG_BITS-1:0]          w_rtag;
    logic                         w_rvalid;
    logic                         w_hit;
    logic                         w_fill;
    logic                         w_clr_all;

    assign w_idx = r_pc[INDEX_BITS+1:2];
    assign w_tag = r_pc[ADDRESS_WIDTH-1 -: TAG_BITS];

    // An invalidate in the lookup cycle turns a would-be hit into a miss.
    assign w_hit = w_rvalid && (w_rtag == w_tag) && !inval_in;

    // Flush wins over a completing refill: the word is dropped unwritten.
    assign w_fill    = rdy_in && !flush_in && (r_state == ST_REFILL) && mem_done_in;
    assign w_clr_all = rdy_in && inval_in;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .i_clk     (clk_in),
        .i_rst_n   (rst_n_in),
        .i_we      (w_fill),
        .i_widx    (w_idx),
        .i_wtag    (w_tag),
        .i_wdata   (mem_inst_in),
        .i_clr_all (w_clr_all),
        .i_ridx    (w_idx),
        .o_rdata   (w_rdata),
        .o_rtag    (w_rtag),
        .o_rvalid  (w_rvalid)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_valid_out <= DISABLE;
            r_inst      <= '0;
            r_mem_pc    <= '0;
        end else if (rdy_in) begin
            r_valid_out <= DISABLE;
            if (flush_in) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ifetch_req_in) begin
                            r_pc    <= word_align(ifetch_pc_in);
                            r_state <= ST_LOOKUP;
                        end
                    end
                    ST_LOOKUP: begin
                        if (w_hit) begin
                            r_valid_out <= ENABLE;
                            r_inst      <= w_rdata;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_mem_pc <= r_pc;
                            r_state  <= ST_REFILL;
                        end
                    end
                    ST_REFILL: begin
                        if (mem_done_in) begin
                            r_valid_out <= ENABLE;
                            r_inst      <= mem_inst_in;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Dropped on the completion cycle so the memory side never re-arms.
    assign mem_en_out       = (r_state == ST_REFILL) && !mem_done_in;
    assign mem_pc_out       = r_mem_pc;
    assign ifetch_rdy_out   = (r_state == ST_IDLE);
    assign ifetch_valid_out = r_valid_out;
    assign ifetch_inst_out  = r_inst;

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

    localparam int IB = 6;
    localparam int NL = 1 << IB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_in;
    logic        req;
    logic [31:0] pc_in;
    logic        rdy_out;
    logic        valid_out;
    logic [31:0] inst_out;
    logic        flush;
    logic        inval;
    logic        mem_en;
    logic [31:0] mem_pc;
    logic        mem_done;
    logic [31:0] mem_inst;

    always #5 clk = ~clk;

    icache_ctrl #(.INDEX_BITS(IB)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .rdy_in           (rdy_in),
        .ifetch_req_in    (req),
        .ifetch_pc_in     (pc_in),
        .ifetch_rdy_out   (rdy_out),
        .ifetch_valid_out (valid_out),
        .ifetch_inst_out  (inst_out),
        .flush_in         (flush),
        .inval_in         (inval),
        .mem_en_out       (mem_en),
        .mem_pc_out       (mem_pc),
        .mem_done_in      (mem_done),
        .mem_inst_in      (mem_inst)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference cache: per index, whether a line is present and which
    // word address it holds.
    bit          m_valid [NL];
    logic [31:0] m_addr  [NL];
    logic [31:0] m_data  [NL];
    logic [31:0] last_inst;

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % NL);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = midx(a);
        return m_valid[i] && (m_addr[i] == (a & 32'hFFFF_FFFC));
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) ^ 32'h1357_9BD3;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        m_valid[midx(a)] = 1'b1;
        m_addr[midx(a)]  = a & 32'hFFFF_FFFC;
        m_data[midx(a)]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        int k;
        k = 0;
        while (rdy_out !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_vec++;
        if (rdy_out !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready: rdy_out=%b required 1 (timeout)", rdy_out);
        end
        req   = 1'b1;
        pc_in = a;
        step();
        req   = 1'b0;
        pc_in = $urandom;
    endtask

    // Full fetch transaction; the model decides hit or miss.
    task automatic run_fetch(input logic [31:0] a, input logic [31:0] word, input int lat);
        bit hit;
        hit = model_hit(a);
        issue(a);
        n_vec++;
        if (valid_out !== 1'b0 || rdy_out !== 1'b0) begin
            n_err++;
            $display("FAIL lookup_cycle pc=%h: valid=%b rdy=%b required 0 0", a, valid_out, rdy_out);
        end
        step();
        if (hit) begin
            last_inst = m_data[midx(a)];
            n_vec++;
            if (valid_out !== 1'b1 || inst_out !== last_inst || mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL hit pc=%h: valid=%b inst=%h mem_en=%b required 1 %h 0",
                         a, valid_out, inst_out, mem_en, last_inst);
            end
        end else begin
            n_vec++;
            if (valid_out !== 1'b0 || mem_en !== 1'b1 || mem_pc !== (a & 32'hFFFF_FFFC)) begin
                n_err++;
                $display("FAIL miss pc=%h: valid=%b mem_en=%b mem_pc=%h required 0 1 %h",
                         a, valid_out, mem_en, mem_pc, a & 32'hFFFF_FFFC);
            end
            for (int c = 0; c < lat; c++) begin
                step();
                n_vec++;
                if (mem_en !== 1'b1 || mem_pc !== (a & 32'hFFFF_FFFC)) begin
                    n_err++;
                    $display("FAIL refill_wait pc=%h: mem_en=%b mem_pc=%h required 1 %h",
                             a, mem_en, mem_pc, a & 32'hFFFF_FFFC);
                end
            end
            mem_done = 1'b1;
            mem_inst = word;
            #1;
            n_vec++;
            if (mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL done_drop pc=%h: mem_en=%b required 0", a, mem_en);
            end
            step();
            mem_done = 1'b0;
            mem_inst = $urandom;
            last_inst = word;
            model_fill(a, word);
            n_vec++;
            if (valid_out !== 1'b1 || inst_out !== word) begin
                n_err++;
                $display("FAIL refill_out pc=%h: valid=%b inst=%h required 1 %h",
                         a, valid_out, inst_out, word);
            end
        end
        step();
        n_vec++;
        if (valid_out !== 1'b0 || inst_out !== last_inst) begin
            n_err++;
            $display("FAIL pulse_hold pc=%h: valid=%b inst=%h required 0 %h",
                     a, valid_out, inst_out, last_inst);
        end
    endtask

    task automatic pulse_inval();
        inval = 1'b1;
        step();
        inval = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy_in = 1'b1; req = 1'b0; pc_in = '0; flush = 1'b0;
        inval = 1'b0; mem_done = 1'b0; mem_inst = '0;
        model_clear();
        last_inst = '0;
        repeat (3) step();
        n_vec++;
        if (rdy_out !== 1'b1 || valid_out !== 1'b0 || mem_en !== 1'b0 ||
            mem_pc !== 32'h0 || inst_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset: rdy=%b valid=%b mem_en=%b mem_pc=%h inst=%h required 1 0 0 0 0",
                     rdy_out, valid_out, mem_en, mem_pc, inst_out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cold_warm();
        run_fetch(32'h0000_0100, 32'h0000_0013, 2);
        run_fetch(32'h0000_0100, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_conflict();
        run_fetch(32'h0000_0200, mem_word(32'h200), 1);
        run_fetch(32'h0000_0100, 32'h0000_0013, 0);
    endtask

    task automatic test_flush_refill();
        issue(32'h0000_0480);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_vec++;
        if (mem_en !== 1'b0 || rdy_out !== 1'b1 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL flush_refill: mem_en=%b rdy=%b valid=%b required 0 1 0",
                     mem_en, rdy_out, valid_out);
        end
        run_fetch(32'h0000_0480, mem_word(32'h480), 1);
    endtask

    task automatic test_flush_done();
        issue(32'h0000_0584);
        step();
        flush    = 1'b1;
        mem_done = 1'b1;
        mem_inst = 32'hBAD0_0001;
        step();
        flush    = 1'b0;
        mem_done = 1'b0;
        n_vec++;
        if (valid_out !== 1'b0 || mem_en !== 1'b0 || rdy_out !== 1'b1) begin
            n_err++;
            $display("FAIL flush_done: valid=%b mem_en=%b rdy=%b required 0 0 1",
                     valid_out, mem_en, rdy_out);
        end
        run_fetch(32'h0000_0584, mem_word(32'h584), 0);
    endtask

    task automatic test_flush_lookup();
        run_fetch(32'h0000_0600, mem_word(32'h600), 0);
        issue(32'h0000_0600);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_vec++;
        if (valid_out !== 1'b0 || mem_en !== 1'b0 || rdy_out !== 1'b1) begin
            n_err++;
            $display("FAIL flush_lookup: valid=%b mem_en=%b rdy=%b required 0 0 1",
                     valid_out, mem_en, rdy_out);
        end
        run_fetch(32'h0000_0600, 32'h0, 0);
    endtask

    task automatic test_inval();
        run_fetch(32'h0000_0100, 32'h0000_0013, 0);
        pulse_inval();
        run_fetch(32'h0000_0100, 32'h0000_0017, 1);
    endtask

    task automatic test_inval_lookup();
        run_fetch(32'h0000_0100, 32'h0000_0013, 0);
        issue(32'h0000_0100);
        inval = 1'b1;
        step();
        inval = 1'b0;
        model_clear();
        n_vec++;
        if (valid_out !== 1'b0 || mem_en !== 1'b1 || mem_pc !== 32'h100) begin
            n_err++;
            $display("FAIL inval_lookup: valid=%b mem_en=%b mem_pc=%h required 0 1 00000100",
                     valid_out, mem_en, mem_pc);
        end
        mem_done = 1'b1;
        mem_inst = 32'h0000_0093;
        step();
        mem_done = 1'b0;
        model_fill(32'h100, 32'h93);
        last_inst = 32'h93;
        step();
        run_fetch(32'h0000_0100, 32'h0, 0);
    endtask

    task automatic test_inval_fill();
        pulse_inval();
        issue(32'h0000_0704);
        step();
        mem_done = 1'b1;
        mem_inst = 32'h0070_4AAA;
        inval    = 1'b1;
        step();
        mem_done = 1'b0;
        inval    = 1'b0;
        model_clear();
        model_fill(32'h704, 32'h0070_4AAA);
        last_inst = 32'h0070_4AAA;
        n_vec++;
        if (valid_out !== 1'b1 || inst_out !== 32'h0070_4AAA) begin
            n_err++;
            $display("FAIL inval_fill: valid=%b inst=%h required 1 00704aaa", valid_out, inst_out);
        end
        step();
        run_fetch(32'h0000_0704, 32'h0, 0);
    endtask

    task automatic test_rdy_stall();
        pulse_inval();
        issue(32'h0000_0008);
        step();
        req   = 1'b1;
        pc_in = 32'h0000_0ABC;
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if (mem_en !== 1'b1 || mem_pc !== 32'h8 || rdy_out !== 1'b0 || valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL rdy_stall c=%0d: mem_en=%b mem_pc=%h rdy=%b valid=%b required 1 00000008 0 0",
                         c, mem_en, mem_pc, rdy_out, valid_out);
            end
        end
        rdy_in = 1'b1;
        step();
        mem_done = 1'b1;
        mem_inst = 32'h0000_0888;
        step();
        mem_done = 1'b0;
        req      = 1'b0;
        model_fill(32'h8, 32'h888);
        last_inst = 32'h888;
        n_vec++;
        if (valid_out !== 1'b1 || inst_out !== 32'h888) begin
            n_err++;
            $display("FAIL rdy_resume: valid=%b inst=%h required 1 00000888", valid_out, inst_out);
        end
        step();
        run_fetch(32'h0000_0008, 32'h0, 0);
    endtask

    task automatic test_reset_mid_refill();
        run_fetch(32'h0000_0100, 32'h0000_0013, 0);
        issue(32'h0000_0340);
        step();
        rst_n    = 1'b0;
        mem_done = 1'b1;
        mem_inst = 32'hBAD0_0340;
        #1;
        n_vec++;
        if (mem_en !== 1'b0 || mem_pc !== 32'h0 || rdy_out !== 1'b1 ||
            valid_out !== 1'b0 || inst_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: mem_en=%b mem_pc=%h rdy=%b valid=%b inst=%h required 0 0 1 0 0",
                     mem_en, mem_pc, rdy_out, valid_out, inst_out);
        end
        step();
        mem_done = 1'b0;
        rst_n    = 1'b1;
        model_clear();
        last_inst = '0;
        step();
        run_fetch(32'h0000_0340, mem_word(32'h340), 0);
        run_fetch(32'h0000_0100, 32'h0000_0013, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) pulse_inval();
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            run_fetch(a, mem_word(a) ^ $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_cold_warm();
        test_conflict();
        test_flush_refill();
        test_flush_done();
        test_flush_lookup();
        test_inval();
        test_inval_lookup();
        test_inval_fill();
        test_rdy_stall();
        test_reset_mid_refill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
